// File: rtl/mlp_ctrl_pkg.sv
// Shared definitions for the MLP controller register interface:
// register map, control-word layout and the host sequencer state encoding.
package mlp_ctrl_pkg;

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_IN0    = 4'h1;
   localparam logic [3:0] ADDR_IN1    = 4'h2;
   localparam logic [3:0] ADDR_IN2    = 4'h3;
   localparam logic [3:0] ADDR_IN3    = 4'h4;
   localparam logic [3:0] ADDR_INSTR  = 4'h5;
   localparam logic [3:0] ADDR_OUT0   = 4'h6;
   localparam logic [3:0] ADDR_OUT1   = 4'h7;
   localparam logic [3:0] ADDR_OUT2   = 4'h8;
   localparam logic [3:0] ADDR_OUT3   = 4'h9;
   localparam logic [3:0] ADDR_STATUS = 4'hA;

   // Control register field positions
   localparam int CTRL_SEND     = 0;
   localparam int CTRL_DEST_LSB = 1;
   localparam int CTRL_OP_LSB   = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_CTRL,
      S_POLL_RD,
      S_POLL_WAIT,
      S_RES_RD,
      S_RES_WAIT,
      S_RSP
   } seq_state_t;

   // Build the control word that launches an MVM op towards a NoC destination
   function automatic logic [31:0] ctrl_word(input logic [1:0] op, input logic [3:0] dest);
      logic [31:0] w;
      w = '0;
      w[CTRL_SEND]                 = 1'b1;
      w[CTRL_DEST_LSB +: 4]        = dest;
      w[CTRL_OP_LSB +: 2]          = op;
      return w;
   endfunction

endpackage

// File: rtl/mlp_host_sequencer.sv
// Host-side initiator for the MLP controller register file. Takes one
// command, writes payload then control, optionally polls for the result
// and reads the four output words back into a single response.
module mlp_host_sequencer
   import mlp_ctrl_pkg::*;
#(
   parameter int POLL_LIMIT = 1024,
   parameter int CNT_W      = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [3:0]   cmd_dest,
   input  logic         cmd_wait,
   input  logic [127:0] cmd_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [127:0] rsp_data,
   output logic         rsp_timeout,
   output logic [3:0]   m_address,
   output logic         m_chipselect,
   output logic         m_read,
   output logic         m_write,
   output logic [31:0]  m_writedata,
   input  logic [31:0]  m_readdata,
   output logic         busy
);

   seq_state_t         r_state, w_next;
   logic [1:0]         r_op;
   logic [3:0]         r_dest;
   logic               r_wait;
   logic [127:0]       r_data;
   logic [1:0]         r_idx;
   logic [CNT_W-1:0]   r_poll_cnt;
   logic [127:0]       r_rsp_data;
   logic               r_timeout;
   logic               w_limit_hit;

   assign w_limit_hit  = (r_poll_cnt == CNT_W'(POLL_LIMIT));
   assign cmd_ready    = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign rsp_valid    = (r_state == S_RSP);
   assign rsp_data     = r_rsp_data;
   assign rsp_timeout  = r_timeout;

   // State register; reset abandons any in-flight transaction
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode and bus strobes, one access per strobe cycle
   always_comb begin
      w_next       = r_state;
      m_address    = 4'h0;
      m_read       = 1'b0;
      m_write      = 1'b0;
      m_writedata  = 32'h0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) w_next = S_WR_DATA;
         end
         S_WR_DATA: begin
            m_write = 1'b1;
            if (r_op == 2'd0) begin
               m_address   = ADDR_INSTR;
               m_writedata = r_data[31:0];
               w_next      = S_WR_CTRL;
            end else begin
               m_address   = ADDR_IN0 + {2'b00, r_idx};
               m_writedata = r_data[{r_idx, 5'b0} +: 32];
               if (r_idx == 2'd3) w_next = S_WR_CTRL;
            end
         end
         S_WR_CTRL: begin
            m_write     = 1'b1;
            m_address   = ADDR_CTRL;
            m_writedata = ctrl_word(r_op, r_dest);
            w_next      = r_wait ? S_POLL_RD : S_RSP;
         end
         S_POLL_RD: begin
            m_read    = 1'b1;
            m_address = ADDR_STATUS;
            w_next    = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            if (m_readdata[0])    w_next = S_RES_RD;
            else if (w_limit_hit) w_next = S_RSP;
            else                  w_next = S_POLL_RD;
         end
         S_RES_RD: begin
            m_read    = 1'b1;
            m_address = ADDR_OUT0 + {2'b00, r_idx};
            w_next    = S_RES_WAIT;
         end
         S_RES_WAIT: begin
            if (r_idx == 2'd3) w_next = S_RSP;
            else               w_next = S_RES_RD;
         end
         S_RSP: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      m_chipselect = m_read | m_write;
   end

   // Command latch, word index, poll counter and response capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op       <= '0;
         r_dest     <= '0;
         r_wait     <= 1'b0;
         r_data     <= '0;
         r_idx      <= '0;
         r_poll_cnt <= '0;
         r_rsp_data <= '0;
         r_timeout  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op       <= cmd_op;
                  r_dest     <= cmd_dest;
                  r_wait     <= cmd_wait;
                  r_data     <= cmd_data;
                  r_idx      <= '0;
                  r_poll_cnt <= '0;
                  r_rsp_data <= '0;
                  r_timeout  <= 1'b0;
               end
            end
            // index wraps back to 0 after the last payload word, ready for result reads
            S_WR_DATA: if (r_op != 2'd0) r_idx <= r_idx + 2'd1;
            S_POLL_RD: if (r_poll_cnt != '1) r_poll_cnt <= r_poll_cnt + 1'b1;
            S_POLL_WAIT: if (!m_readdata[0] && w_limit_hit) r_timeout <= 1'b1;
            S_RES_WAIT: begin
               r_rsp_data[{r_idx, 5'b0} +: 32] <= m_readdata;
               r_idx <= r_idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
